// File: rtl/ysyx_040066_mem_access.sv
// MEM stage: registers EX results and runs one req/ack data-bus transaction per load/store.
// Optional MEM_TIMEOUT_EN aborts a WAIT that lasts TIMEOUT_CYCLES without ack.
module ysyx_040066_mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        wen_in,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic        done_in,
  input  logic        error_in,
  input  logic [4:0]  rd_in,
  input  logic [63:0] alu_in,
  input  logic [63:0] store_in,
  input  logic [63:0] nxtpc_in,
  input  logic [2:0]  MemOp_in,
  input  logic        block_ext,
  output logic        valid_out,
  output logic        wen_out,
  output logic        MemRd_out,
  output logic        MemWr_out,
  output logic        done_out,
  output logic        error_out,
  output logic [4:0]  rd_out,
  output logic [63:0] data_out,
  output logic [63:0] nxtpc_out,
  output logic [2:0]  MemOp_out,
  output logic [2:0]  addr_lowbit_out,
  output logic [63:0] data_Rd,
  output logic        data_error,
  output logic        block,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] store_q;
  logic        mem_op;
  logic        aligned;
  logic        fault;
  logic        acked;
  logic        timeout_hit;
  logic [2:0]  a;

  // Stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      wen_out   <= 1'b0;
      MemRd_out <= 1'b0;
      MemWr_out <= 1'b0;
      done_out  <= 1'b0;
      error_out <= 1'b0;
      rd_out    <= '0;
      data_out  <= '0;
      nxtpc_out <= '0;
      MemOp_out <= '0;
      store_q   <= '0;
    end else if (!block) begin
      valid_out <= valid_in;
      wen_out   <= wen_in;
      MemRd_out <= MemRd_in;
      MemWr_out <= MemWr_in;
      done_out  <= done_in;
      error_out <= error_in;
      rd_out    <= rd_in;
      data_out  <= alu_in;
      nxtpc_out <= nxtpc_in;
      MemOp_out <= MemOp_in;
      store_q   <= store_in;
    end
  end

  assign a               = data_out[2:0];
  assign addr_lowbit_out = a;
  assign mem_op          = valid_out && (MemRd_out || MemWr_out);

  always_comb begin
    aligned = 1'b1;
    case (MemOp_out[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = !a[0];
      2'd2:    aligned = (a[1:0] == 2'b00);
      default: aligned = (a == 3'b000);
    endcase
  end

  always_comb begin
    mem_wmask = 8'hFF;
    case (MemOp_out[1:0])
      2'd0:    mem_wmask = 8'h01 << a;
      2'd1:    mem_wmask = 8'h03 << a;
      2'd2:    mem_wmask = 8'h0F << a;
      default: mem_wmask = 8'hFF;
    endcase
  end

  assign mem_wr    = valid_out && MemWr_out;
  assign mem_addr  = {data_out[63:3], 3'b000};
  assign mem_wdata = mem_wr ? (store_q << {a, 3'b000}) : '0;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wait_cnt;

  // Held at zero outside WAIT, so it starts from zero on every entry
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + CW'(1);
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES)) && !mem_ack;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    fault     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            mem_req   = 1'b1;
            state_nxt = mem_ack ? S_DONE : S_WAIT;
          end else begin
            fault     = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (timeout_hit) begin
          fault     = 1'b1;
          state_nxt = S_DONE;
        end else begin
          mem_req = mem_op;
          if (mem_ack) state_nxt = S_DONE;
        end
      end
      S_DONE: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign acked = mem_req && mem_ack;
  assign block = rst ? block_ext
                     : (block_ext || (mem_op && state != S_DONE && !mem_ack && !timeout_hit));

  // Every stage-register load restarts the FSM for the new op
  always_ff @(posedge clk) begin
    if (rst || !block) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_Rd    <= '0;
      data_error <= 1'b0;
    end else if (acked) begin
      if (!mem_wr) data_Rd <= mem_rdata;
      data_error <= mem_err;
    end else if (fault) begin
      data_Rd    <= '0;
      data_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_040066_mem_access.sv
// Directed bench for ysyx_040066_mem_access; define MEM_TIMEOUT_EN to also run the timeout case.
module tb_ysyx_040066_mem_access;

`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, wen_in, MemRd_in, MemWr_in, done_in, error_in;
  logic [4:0]  rd_in;
  logic [63:0] alu_in, store_in, nxtpc_in;
  logic [2:0]  MemOp_in;
  logic        block_ext;
  logic        valid_out, wen_out, MemRd_out, MemWr_out, done_out, error_out;
  logic [4:0]  rd_out;
  logic [63:0] data_out, nxtpc_out;
  logic [2:0]  MemOp_out, addr_lowbit_out;
  logic [63:0] data_Rd;
  logic        data_error, block;
  logic        mem_req, mem_wr;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_040066_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .wen_in(wen_in), .MemRd_in(MemRd_in), .MemWr_in(MemWr_in),
    .done_in(done_in), .error_in(error_in), .rd_in(rd_in), .alu_in(alu_in),
    .store_in(store_in), .nxtpc_in(nxtpc_in), .MemOp_in(MemOp_in), .block_ext(block_ext),
    .valid_out(valid_out), .wen_out(wen_out), .MemRd_out(MemRd_out), .MemWr_out(MemWr_out),
    .done_out(done_out), .error_out(error_out), .rd_out(rd_out), .data_out(data_out),
    .nxtpc_out(nxtpc_out), .MemOp_out(MemOp_out), .addr_lowbit_out(addr_lowbit_out),
    .data_Rd(data_Rd), .data_error(data_error), .block(block),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input logic v, input logic rdq, input logic wrq, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] st, input logic [2:0] op);
    valid_in = v;
    MemRd_in = rdq;
    MemWr_in = wrq;
    wen_in   = rdq;
    done_in  = 1'b0;
    error_in = 1'b0;
    rd_in    = rd;
    alu_in   = alu;
    store_in = st;
    nxtpc_in = 64'h8000_1000 + 64'(rd);
    MemOp_in = op;
  endtask

  task automatic bubble;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 3'd0);
  endtask

  logic [63:0] st_addr [3] = '{64'h8000_0002, 64'h8000_0004, 64'h8000_0008};
  logic [63:0] st_data [3] = '{64'h0000_0000_0000_BEEF, 64'h0000_0000_1234_5678, 64'h0123_4567_89AB_CDEF};
  logic [2:0]  st_op   [3] = '{3'd1, 3'd2, 3'd3};
  logic [63:0] st_wd   [3] = '{64'h0000_0000_BEEF_0000, 64'h1234_5678_0000_0000, 64'h0123_4567_89AB_CDEF};
  logic [7:0]  st_wm   [3] = '{8'h0C, 8'hF0, 8'hFF};
  logic [63:0] st_ma   [3] = '{64'h8000_0000, 64'h8000_0000, 64'h8000_0008};

  initial begin
    rst = 1'b1; block_ext = 1'b0; mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    bubble();
    repeat (3) tick();
    settle();
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_data_Rd", data_Rd, 64'd0);
    check("rst_data_error", 64'(data_error), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_block", 64'(block), 64'd0);
    rst = 1'b0;

    // lw 0x80000004, ack in the fourth request cycle
    drive(1'b1, 1'b1, 1'b0, 5'd5, 64'h8000_0004, 64'd0, 3'd2);
    tick(); bubble(); settle();
    check("lw_valid", 64'(valid_out), 64'd1);
    check("lw_rd", 64'(rd_out), 64'd5);
    check("lw_lowbit", 64'(addr_lowbit_out), 64'd4);
    check("lw_addr", mem_addr, 64'h8000_0000);
    check("lw_wr", 64'(mem_wr), 64'd0);
    check("lw_req0", 64'(mem_req), 64'd1);
    check("lw_block0", 64'(block), 64'd1);
    for (int i = 1; i < 3; i++) begin
      tick(); settle();
      check("lw_req_wait", 64'(mem_req), 64'd1);
      check("lw_block_wait", 64'(block), 64'd1);
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
    settle();
    check("lw_ack_req", 64'(mem_req), 64'd1);
    check("lw_ack_block", 64'(block), 64'd0);
    tick(); mem_ack = 1'b0; settle();
    check("lw_data_Rd", data_Rd, 64'h1122_3344_5566_7788);
    check("lw_data_error", 64'(data_error), 64'd0);
    check("lw_advanced", 64'(valid_out), 64'd0);

    // sb 0x80000003, zero-wait ack
    drive(1'b1, 1'b0, 1'b1, 5'd0, 64'h8000_0003, 64'h0000_0000_0000_00AB, 3'd0);
    tick(); bubble();
    mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    settle();
    check("sb_req", 64'(mem_req), 64'd1);
    check("sb_wr", 64'(mem_wr), 64'd1);
    check("sb_wmask", 64'(mem_wmask), 64'h08);
    check("sb_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
    check("sb_addr", mem_addr, 64'h8000_0000);
    check("sb_block", 64'(block), 64'd0);
    tick(); mem_ack = 1'b0; settle();
    check("sb_keeps_data_Rd", data_Rd, 64'h1122_3344_5566_7788);
    check("sb_data_error", 64'(data_error), 64'd0);

    // sh / sw / sd lane placement
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 5'd0, st_addr[i], st_data[i], st_op[i]);
      tick(); bubble(); mem_ack = 1'b1; settle();
      check("st_wmask", 64'(mem_wmask), 64'(st_wm[i]));
      check("st_wdata", mem_wdata, st_wd[i]);
      check("st_addr", mem_addr, st_ma[i]);
      check("st_block", 64'(block), 64'd0);
      tick(); mem_ack = 1'b0; settle();
    end

    // lh 0x80000001: misaligned, never requested
    drive(1'b1, 1'b1, 1'b0, 5'd6, 64'h8000_0001, 64'd0, 3'd1);
    tick(); bubble(); settle();
    check("lh_mis_req", 64'(mem_req), 64'd0);
    tick(); settle();
    check("lh_mis_error", 64'(data_error), 64'd1);
    check("lh_mis_data_Rd", data_Rd, 64'd0);
    check("lh_mis_block", 64'(block), 64'd0);
    check("lh_mis_req_done", 64'(mem_req), 64'd0);
    check("lh_mis_held", 64'(rd_out), 64'd6);
    tick(); settle();

    // back-to-back ld with zero-wait acks
    drive(1'b1, 1'b1, 1'b0, 5'd8, 64'h8000_0010, 64'd0, 3'd3);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd9, 64'h8000_0018, 64'd0, 3'd3);
    mem_ack = 1'b1; mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    settle();
    check("ld1_addr", mem_addr, 64'h8000_0010);
    check("ld1_block", 64'(block), 64'd0);
    tick(); bubble(); mem_rdata = 64'hBBBB_BBBB_BBBB_BBBB; settle();
    check("ld1_data_Rd", data_Rd, 64'hAAAA_AAAA_AAAA_AAAA);
    check("ld1_error_clr", 64'(data_error), 64'd0);
    check("ld2_addr", mem_addr, 64'h8000_0018);
    check("ld2_rd", 64'(rd_out), 64'd9);
    check("ld2_block", 64'(block), 64'd0);
    tick(); mem_ack = 1'b0; settle();
    check("ld2_data_Rd", data_Rd, 64'hBBBB_BBBB_BBBB_BBBB);

`ifdef MEM_TIMEOUT_EN
    // lw never acked: 1 IDLE + 4 WAIT request cycles, then abort
    drive(1'b1, 1'b1, 1'b0, 5'd12, 64'h8000_0040, 64'd0, 3'd2);
    tick(); bubble(); settle();
    check("to_req_idle", 64'(mem_req), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check("to_req_wait", 64'(mem_req), 64'd1);
      check("to_block_wait", 64'(block), 64'd1);
    end
    tick(); settle();
    check("to_req_drop", 64'(mem_req), 64'd0);
    check("to_block_drop", 64'(block), 64'd0);
    tick(); settle();
    check("to_error", 64'(data_error), 64'd1);
    check("to_data_Rd", data_Rd, 64'd0);
    check("to_advanced", 64'(valid_out), 64'd0);
`endif

    // lw acked with mem_err while block_ext holds the pipe
    drive(1'b1, 1'b1, 1'b0, 5'd10, 64'h8000_0020, 64'd0, 3'd2);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd11, 64'h0000_0000_0000_1234, 64'd0, 3'd0);
    block_ext = 1'b1; mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    settle();
    check("be_ack_req", 64'(mem_req), 64'd1);
    check("be_ack_block", 64'(block), 64'd1);
    tick(); mem_ack = 1'b0; mem_err = 1'b0; settle();
    check("be_req_after", 64'(mem_req), 64'd0);
    check("be_error", 64'(data_error), 64'd1);
    check("be_data_Rd", data_Rd, 64'h5555_5555_5555_5555);
    check("be_hold1", 64'(rd_out), 64'd10);
    tick(); settle();
    check("be_req_after2", 64'(mem_req), 64'd0);
    check("be_hold2", 64'(rd_out), 64'd10);
    tick(); block_ext = 1'b0; settle();
    check("be_release", 64'(block), 64'd0);
    check("be_error_held", 64'(data_error), 64'd1);
    tick(); settle();
    check("be_adv_rd", 64'(rd_out), 64'd11);
    check("be_adv_data", data_out, 64'h0000_0000_0000_1234);
    check("be_adv_memrd", 64'(MemRd_out), 64'd0);
    bubble();
    tick(); settle();

    // reset while in WAIT, then a late ack that must be ignored
    drive(1'b1, 1'b1, 1'b0, 5'd13, 64'h8000_0048, 64'd0, 3'd2);
    tick(); bubble(); settle();
    check("rw_req_idle", 64'(mem_req), 64'd1);
    tick(); settle();
    check("rw_req_wait", 64'(mem_req), 64'd1);
    rst = 1'b1;
    tick(); rst = 1'b0; settle();
    check("rw_req_drop", 64'(mem_req), 64'd0);
    check("rw_valid", 64'(valid_out), 64'd0);
    check("rw_block", 64'(block), 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    settle();
    check("rw_late_req", 64'(mem_req), 64'd0);
    tick(); mem_ack = 1'b0; settle();
    check("rw_late_data_Rd", data_Rd, 64'd0);
    check("rw_late_error", 64'(data_error), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
